// File: rtl/uart_stream_pkg.sv
// Shared FSM encodings, parity-select constants and parity helper for uart_stream.
package uart_stream_pkg;

    typedef enum logic [2:0] {
        TxIdle,
        TxStart,
        TxData,
        TxParity,
        TxStop
    } tx_state_e;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxParity,
        RxStop,
        RxWaitHigh
    } rx_state_e;

    localparam bit ParityEven = 1'b0;
    localparam bit ParityOdd  = 1'b1;

    // Parity over the low 'bits' bits of data; seeding with 1 yields odd parity.
    function automatic logic calc_parity(input logic [7:0] data, input int unsigned bits,
                                         input bit odd);
        logic p;
        p = odd;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < bits) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_stream_fifo.sv
// Synchronous FIFO for received UART beats; a push while full is accepted only alongside a pop.
module uart_stream_fifo #(
    parameter int unsigned Width = 9,
    parameter int unsigned Depth = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam logic [AddrW:0] PtrOne = 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= wdata;
        end
    end

    // Head is forced to zero when empty so the stream reads clean after reset.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

endmodule

// File: rtl/uart_stream.sv
// UART <-> valid/ready stream bridge with buffered RX.
// Optional parity bit (send and check) enabled by defining UART_STREAM_PARITY_EN.
module uart_stream
    import uart_stream_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned STOP_BITS     = 1,
    parameter int unsigned PARITY_ODD    = 0,
    parameter int unsigned RX_FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       UART_RXD,
    output logic       UART_TXD,
    output logic [7:0] from_uart_data,
    output logic       from_uart_error,
    output logic       from_uart_valid,
    input  logic       from_uart_ready,
    input  logic [7:0] to_uart_data,
    input  logic       to_uart_error,
    input  logic       to_uart_valid,
    output logic       to_uart_ready
);

`ifdef UART_STREAM_PARITY_EN
    localparam bit ParityEn = 1'b1;
`else
    localparam bit ParityEn = 1'b0;
`endif
    localparam bit          OddSel   = (PARITY_ODD != 0) ? ParityOdd : ParityEven;
    localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]  DataLast = 3'(DATA_BITS - 1);
    localparam logic [2:0]  StopLast = 3'(STOP_BITS - 1);

    // ---------------- TX ----------------
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_par_q, tx_par_d;
    logic        txd_q, txd_d;
    logic        tx_ready_q, tx_ready_d;
    logic        tx_bit_end, tx_take;

    assign tx_bit_end    = (tx_cnt_q == BitLast);
    assign tx_take       = to_uart_valid && tx_ready_q;
    assign UART_TXD      = txd_q;
    assign to_uart_ready = tx_ready_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_data_q  <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_data_q  <= tx_data_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_data_d  = tx_data_q;
        tx_par_d   = tx_par_q;
        if (tx_state_q != TxIdle) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 16'd1;
        end
        unique case (tx_state_q)
            TxIdle: begin
                // Error beats are consumed here without leaving idle.
                if (tx_take && !to_uart_error) begin
                    tx_state_d = TxStart;
                    tx_cnt_d   = '0;
                    tx_data_d  = to_uart_data;
                    tx_par_d   = calc_parity(to_uart_data, DATA_BITS, OddSel);
                end
            end
            TxStart: begin
                if (tx_bit_end) begin
                    tx_state_d = TxData;
                    tx_idx_d   = '0;
                end
            end
            TxData: begin
                if (tx_bit_end) begin
                    if (tx_idx_q == DataLast) begin
                        tx_state_d = ParityEn ? TxParity : TxStop;
                        tx_idx_d   = '0;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                    end
                end
            end
            TxParity: begin
                if (tx_bit_end) begin
                    tx_state_d = TxStop;
                    tx_idx_d   = '0;
                end
            end
            TxStop: begin
                if (tx_bit_end) begin
                    if (tx_idx_q == StopLast) begin
                        tx_state_d = TxIdle;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                    end
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    // Outputs are registered from the next state so the line changes with the state.
    always_comb begin
        txd_d      = 1'b1;
        tx_ready_d = (tx_state_d == TxIdle);
        unique case (tx_state_d)
            TxStart:  txd_d = 1'b0;
            TxData:   txd_d = tx_data_d[tx_idx_d];
            TxParity: txd_d = tx_par_d;
            default:  txd_d = 1'b1;
        endcase
    end

    // ---------------- RX ----------------
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_par_err_q, rx_par_err_d;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic        rx_fall, rx_bit_end;
    logic        wr_pend_q, wr_pend_d;
    logic        wr_err_q, wr_err_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        overrun_q, overrun_d;
    logic        fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [8:0]  fifo_rdata;

    assign rx_fall    = rx_prev_q && !rx_sync_q;
    assign rx_bit_end = (rx_cnt_q == BitLast);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RxIdle;
            rx_cnt_q     <= '0;
            rx_idx_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_err_q <= 1'b0;
            wr_pend_q    <= 1'b0;
            wr_err_q     <= 1'b0;
            wr_data_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= UART_RXD;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_idx_q     <= rx_idx_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_err_q <= rx_par_err_d;
            wr_pend_q    <= wr_pend_d;
            wr_err_q     <= wr_err_d;
            wr_data_q    <= wr_data_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q + 16'd1;
        rx_idx_d     = rx_idx_q;
        rx_shift_d   = rx_shift_q;
        rx_par_err_d = rx_par_err_q;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rx_fall) begin
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_state_d   = rx_sync_q ? RxIdle : RxData;
                    rx_cnt_d     = '0;
                    rx_idx_d     = '0;
                    rx_shift_d   = '0;
                    rx_par_err_d = 1'b0;
                end
            end
            RxData: begin
                if (rx_bit_end) begin
                    rx_cnt_d             = '0;
                    rx_shift_d[rx_idx_q] = rx_sync_q;
                    if (rx_idx_q == DataLast) begin
                        rx_state_d = ParityEn ? RxParity : RxStop;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end
            end
            RxParity: begin
                if (rx_bit_end) begin
                    rx_cnt_d     = '0;
                    rx_par_err_d = rx_sync_q ^ calc_parity(rx_shift_q, DATA_BITS, OddSel);
                    rx_state_d   = RxStop;
                end
            end
            RxStop: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync_q ? RxIdle : RxWaitHigh;
                end
            end
            RxWaitHigh: begin
                rx_cnt_d = '0;
                if (rx_sync_q) begin
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // Beat is captured at the stop sample and pushed on the following edge.
    always_comb begin
        wr_pend_d = 1'b0;
        wr_err_d  = wr_err_q;
        wr_data_d = wr_data_q;
        if (rx_state_q == RxStop && rx_bit_end) begin
            wr_pend_d = 1'b1;
            wr_err_d  = !rx_sync_q || (ParityEn && rx_par_err_q);
            wr_data_d = rx_shift_q;
        end
        fifo_push = wr_pend_q && (!fifo_full || fifo_pop);
        overrun_d = overrun_q;
        if (wr_pend_q) begin
            overrun_d = !fifo_push;
        end
    end

    assign fifo_pop        = from_uart_valid && from_uart_ready;
    assign from_uart_valid = !fifo_empty;
    assign from_uart_data  = fifo_rdata[7:0];
    assign from_uart_error = fifo_rdata[8];

    uart_stream_fifo #(
        .Width (9),
        .Depth (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({wr_err_q || overrun_q, wr_data_q}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: doc/uart_stream.md
UART_STREAM -- requirements
Module: uart_stream

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per bit (legal range 8..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal range 5..8).
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits transmitted (legal values 1 or 2).
REQ-004 SHALL have parameter PARITY_ODD, default 0, selecting odd (1) or even (0) parity; used only with UART_STREAM_PARITY_EN.
REQ-005 SHALL have parameter RX_FIFO_DEPTH, default 16, RX buffer entries (power of 2, minimum 2).
REQ-006 SHALL have port clk, input, 1 bit: sole clock.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port UART_RXD, input, 1 bit: serial line in, asynchronous to clk.
REQ-009 SHALL have port UART_TXD, output, 1 bit: serial line out, idle high.
REQ-010 SHALL have from_uart_data (output, 8), from_uart_error (output, 1), from_uart_valid (output, 1) and from_uart_ready (input, 1) as the RX stream.
REQ-011 SHALL have to_uart_data (input, 8), to_uart_error (input, 1), to_uart_valid (input, 1) and to_uart_ready (output, 1) as the TX stream.

Function
REQ-012 SHALL run TX FSM IDLE->START->DATA->PARITY->STOP->IDLE; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-013 SHALL drive to_uart_ready=1 only in IDLE; transfer occurs on to_uart_valid&&to_uart_ready.
REQ-014 SHALL drive the start bit (0) on the cycle after the transfer.
REQ-015 SHALL send to_uart_data[DATA_BITS-1:0] LSB first; higher bits are ignored.
REQ-016 SHALL accept and discard a beat with to_uart_error=1: no frame sent, and the FSM remains in IDLE.
REQ-017 SHALL pass RX through a 2-flop synchroniser; a 1->0 edge in RX IDLE starts a frame.
REQ-018 SHALL re-check the start bit at CLKS_PER_BIT/2; if high, treat it as a false start and return to IDLE with no FIFO write.
REQ-019 SHALL sample data, parity and one stop bit at bit mid-points, assembling LSB first, with upper bits zero-filled.
REQ-020 SHALL write {error, data} to the FIFO one cycle after the stop-bit sample; error = stop bit low (framing) OR parity mismatch OR pending overrun.
REQ-021 SHALL handle FIFO full at write time by dropping the frame and setting a sticky overrun flag; the flag ORs into the next written entry's error, then clears.
REQ-022 SHALL resume start detection immediately after the stop-bit sample; a framing-error frame waits for the line to return high first.
REQ-023 SHALL drive from_uart_valid = FIFO not empty; data and error present the head entry and are held stable while valid&&!ready.
REQ-024 SHALL pop on from_uart_valid&&from_uart_ready; a simultaneous push and pop when full is not an overrun.

Reset
REQ-025 SHALL set, while reset=0: UART_TXD=1, to_uart_ready=0, from_uart_valid=0, from_uart_data=0, from_uart_error=0, FIFO empty, overrun flag clear, both FSMs IDLE.
REQ-026 SHALL drive to_uart_ready=1 on the first clk edge after reset deasserts.
REQ-027 SHALL discard any frame in flight when reset asserts mid-frame; TXD goes high immediately.

Configuration
REQ-028 SHALL, with UART_STREAM_PARITY_EN defined, send and check a PARITY_ODD-selected parity bit between the data and stop bits.
REQ-029 SHALL, without UART_STREAM_PARITY_EN, omit the PARITY state and parity check; error then covers framing and overrun only.

Structure
REQ-030 SHALL place the TX/RX state enums and the parity-select constants in package uart_stream_pkg.
REQ-031 SHALL implement the RX buffer as sub-module uart_stream_fifo, parameterised by width 9 and RX_FIFO_DEPTH.

Verification
REQ-032 SHALL cover TX, with CLKS_PER_BIT=16, 8N1: send 0xA5 -> TXD reads 0,1,0,1,0,0,1,0,1,1 with 16 cycles per bit, and to_uart_ready=0 for 160 cycles.
REQ-033 SHALL cover RX of 0x3C with a valid stop bit -> one beat, data 0x3C, error 0.
REQ-034 SHALL cover a 4-cycle low glitch on RXD -> no FIFO write; valid stays 0.
REQ-035 SHALL cover a frame 0x55 with stop bit 0 -> data 0x55, error 1; the next good frame has error 0.
REQ-036 SHALL cover, with RX_FIFO_DEPTH=4 and ready=0, 6 frames received -> 4 beats held; after draining, the 7th frame has error 1.
REQ-037 SHALL cover, with parity enabled and even parity, an RX frame 0x07 carrying parity bit 0 -> error 1.
